// File: rtl/nesmx_loader_pkg.sv
// Shared definitions for the boot-time flash-to-SPRAM ROM loader.
// Contents: loader FSM state enum, iNES header magic words, header size.
package nesmx_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StRead,
        StWrite,
        StDone,
        StErr
    } loader_state_e;

    // "NE" then "S\x1A", little-endian byte order as delivered by the reader.
    localparam logic [15:0] HDR_MAGIC0 = 16'h454E;
    localparam logic [15:0] HDR_MAGIC1 = 16'h1A53;
    localparam int unsigned HDR_BYTES  = 16;

endpackage

// File: rtl/flash_rom_loader.sv
// Boot-time copier: requests WORDS 16-bit words from the SPI flash word reader
// and writes them sequentially into SPRAM, then holds done.
// Optional feature macro: NESMX_ROM_HDR_EN (check the iNES magic and skip the
// 16-byte header before copying; otherwise error is tied low).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start                   pulse to begin a load (ignored while busy)
//   busy, done, error       status; done/error held until start or reset
//   flash_valid/addr        request to flash reader, held until flash_ready
//   flash_ready/rdata       one-cycle read-data pulse from flash reader
//   mem_wr/addr/wdata       SPRAM write port, held while mem_busy
//   mem_busy                SPRAM cannot accept a write this cycle
module flash_rom_loader
    import nesmx_loader_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h100000,
    parameter int unsigned WORDS      = 16384,
    parameter int unsigned MEM_AW     = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              flash_valid,
    output logic [23:0]       flash_addr,
    input  logic              flash_ready,
    input  logic [15:0]       flash_rdata,
    output logic              mem_wr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_busy
);

    localparam int unsigned IDX_W = MEM_AW + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
`ifdef NESMX_ROM_HDR_EN
    localparam logic [23:0] DATA_BASE = FLASH_BASE + 24'(HDR_BYTES);
`else
    localparam logic [23:0] DATA_BASE = FLASH_BASE;
`endif

    loader_state_e    state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [15:0]      hold_q, hold_d;
    logic [23:0]      faddr_q, faddr_d;
    logic             fvalid_q, fvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wr_q, wr_d;
    logic             fetch_ack;

    // Only a ready that answers an outstanding request counts.
    assign fetch_ack = fvalid_q & flash_ready;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        hold_d  = hold_q;
        faddr_d = faddr_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    index_d = '0;
`ifdef NESMX_ROM_HDR_EN
                    state_d = StHdr0;
                    faddr_d = FLASH_BASE;
`else
                    state_d = StRead;
                    faddr_d = DATA_BASE;
`endif
                end
            end
`ifdef NESMX_ROM_HDR_EN
            StHdr0: begin
                if (fetch_ack) begin
                    if (flash_rdata == HDR_MAGIC0) begin
                        state_d = StHdr1;
                        faddr_d = FLASH_BASE + 24'd2;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StHdr1: begin
                if (fetch_ack) begin
                    if (flash_rdata == HDR_MAGIC1) begin
                        state_d = StRead;
                        faddr_d = DATA_BASE;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
`endif
            StRead: begin
                if (fetch_ack) begin
                    hold_d  = flash_rdata;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (!mem_busy) begin
                    if (index_q == LAST_IDX) begin
                        state_d = StDone;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = StRead;
                        faddr_d = DATA_BASE + 24'({index_d, 1'b0});
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered strobes are decoded from the next state; dropping valid on
        // the ack cycle guarantees an idle cycle between consecutive requests.
        fvalid_d = ((state_d == StRead) || (state_d == StHdr0) || (state_d == StHdr1))
                   && !fetch_ack;
        busy_d   = !((state_d == StIdle) || (state_d == StDone) || (state_d == StErr));
        done_d   = (state_d == StDone);
        wr_d     = (state_d == StWrite);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            index_q  <= '0;
            hold_q   <= '0;
            faddr_q  <= '0;
            fvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            hold_q   <= hold_d;
            faddr_q  <= faddr_d;
            fvalid_q <= fvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_q     <= wr_d;
        end
    end

`ifdef NESMX_ROM_HDR_EN
    logic error_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= (state_d == StErr);
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign flash_valid = fvalid_q;
    assign flash_addr  = faddr_q;
    assign mem_wr      = wr_q;
    assign mem_addr    = index_q[MEM_AW-1:0];
    assign mem_wdata   = hold_q;

endmodule

// File: tb/tb_flash_rom_loader.sv
// Directed bench for flash_rom_loader with a 100-cycle behavioural flash reader
// (word = addr[16:1], or the iNES magic when hdr_good is set) and an SPRAM model.
module tb_flash_rom_loader;

    localparam int unsigned MEM_AW = 14;
    localparam int unsigned WORDS  = 4;
`ifdef NESMX_ROM_HDR_EN
    localparam int unsigned HDR_REQS = 2;
    localparam logic [15:0] DW0      = 16'h0008;
`else
    localparam int unsigned HDR_REQS = 0;
    localparam logic [15:0] DW0      = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, error;
    logic              flash_valid;
    logic [23:0]       flash_addr;
    logic              flash_ready = 1'b0;
    logic [15:0]       flash_rdata = 16'h0;
    logic              mem_wr;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_busy = 1'b0;

    int checks = 0;
    int failures = 0;

    flash_rom_loader #(
        .FLASH_BASE(24'h100000),
        .WORDS     (WORDS),
        .MEM_AW    (MEM_AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .flash_valid(flash_valid),
        .flash_addr (flash_addr),
        .flash_ready(flash_ready),
        .flash_rdata(flash_rdata),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_busy   (mem_busy)
    );

    always #5 clk = ~clk;

    // Flash reader model
    bit          hdr_good = 1'b0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [23:0] paddr = 24'h0;
    int          req_cnt = 0;
    int          addr_glitch = 0;
    logic [23:0] req_addr [0:63];

    function automatic logic [15:0] flash_word(input logic [23:0] a, input bit good);
        if (good && a == 24'h100000) return 16'h454E;
        if (good && a == 24'h100002) return 16'h1A53;
        return a[16:1];
    endfunction

    always @(posedge clk) begin
        flash_ready <= 1'b0;
        if (reset) begin
            pend <= 1'b0;
        end else if (pend) begin
            if (flash_valid && flash_addr != paddr) addr_glitch <= addr_glitch + 1;
            if (cnt == 1) begin
                flash_ready <= 1'b1;
                flash_rdata <= flash_word(paddr, hdr_good);
                pend        <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (flash_valid && !flash_ready) begin
            pend  <= 1'b1;
            cnt   <= 100;
            paddr <= flash_addr;
            req_addr[req_cnt[5:0]] <= flash_addr;
            req_cnt <= req_cnt + 1;
        end
    end

    // SPRAM model
    logic [15:0] mem [0:15];
    int          writes = 0;
    always @(posedge clk) begin
        if (!reset && mem_wr && !mem_busy) begin
            mem[mem_addr[3:0]] <= mem_wdata;
            writes <= writes + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!flash_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!flash_ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!done && !error && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done && !error) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int wr_base;
    int rq_base;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_fvalid", {31'd0, flash_valid}, 32'd0);
        check("rst_memwr", {31'd0, mem_wr}, 32'd0);
        check("rst_addrs", {flash_addr, 8'd0} | {18'd0, mem_addr}, 32'd0);
        check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

`ifdef NESMX_ROM_HDR_EN
        // Good header: data copy starts after the 16-byte header.
        hdr_good = 1'b1;
        wr_base = writes;
        rq_base = req_cnt;
        pulse_start();
        check("hdr_req0_valid", {31'd0, flash_valid}, 32'd1);
        check("hdr_req0_addr", {8'd0, flash_addr}, 32'h100000);
        wait_end("hdr_good", 3000);
        @(negedge clk);
        check("hdr_good_done", {30'd0, done, error}, 32'b10);
        check("hdr_req1", {8'd0, req_addr[rq_base + 1]}, 32'h100002);
        check("hdr_req2", {8'd0, req_addr[rq_base + 2]}, 32'h100010);
        check("hdr_mem0", {16'd0, mem[0]}, 32'h0008);
        check("hdr_mem3", {16'd0, mem[3]}, 32'h000B);
        check("hdr_writes", writes - wr_base, 32'd4);
        // Bad header: error without HDR1 request or writes.
        hdr_good = 1'b0;
        wr_base = writes;
        rq_base = req_cnt;
        pulse_start();
        check("bad_clr_done", {31'd0, done}, 32'd0);
        wait_end("hdr_bad", 500);
        repeat (5) @(negedge clk);
        check("bad_error", {30'd0, error, busy}, 32'b10);
        check("bad_done", {31'd0, done}, 32'd0);
        check("bad_writes", writes - wr_base, 32'd0);
        check("bad_reqs", req_cnt - rq_base, 32'd1);
        hdr_good = 1'b1;
`else
        // Plain load with timing points and a 5-cycle mem_busy stall on word 2.
        wr_base = writes;
        rq_base = req_cnt;
        pulse_start();
        check("start_valid", {31'd0, flash_valid}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("req0_addr", {8'd0, flash_addr}, 32'h100000);
        wait_ready("w0");
        @(negedge clk);
        check("w0_wr", {31'd0, mem_wr}, 32'd1);
        check("w0_addr_data", {2'd0, mem_addr, mem_wdata}, 32'h0000_0000);
        check("w0_fvalid_low", {31'd0, flash_valid}, 32'd0);
        @(negedge clk);
        check("req1_valid", {31'd0, flash_valid}, 32'd1);
        check("req1_addr", {8'd0, flash_addr}, 32'h100002);
        wait_ready("w1");
        @(negedge clk);
        wait_ready("w2");
        @(negedge clk);
        check("w2_wr", {2'd0, mem_wr, mem_addr, mem_wdata}, {2'd0, 1'b1, 14'd2, 16'h0002});
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", {1'b0, flash_valid, mem_wr, mem_addr, mem_wdata},
                  {1'b0, 1'b0, 1'b1, 14'd2, 16'h0002});
        end
        mem_busy = 1'b0;
        @(negedge clk);
        check("stall_one_write", writes - wr_base, 32'd3);
        check("req3_addr", {8'd0, flash_addr}, 32'h100006);
        wait_ready("w3");
        @(negedge clk);
        check("w3_wr", {1'b0, done, mem_wr, mem_addr, mem_wdata},
              {1'b0, 1'b0, 1'b1, 14'd3, 16'h0003});
        @(negedge clk);
        check("done_timing", {30'd0, done, busy}, 32'b10);
        check("l1_writes", writes - wr_base, 32'd4);
        check("l1_reqs", req_cnt - rq_base, 32'd4);
        check("l1_req2", {8'd0, req_addr[rq_base + 2]}, 32'h100004);
        check("l1_mem", {mem[0][3:0], mem[1][3:0], mem[2][3:0], mem[3][3:0]}, 32'h0123);
`endif
        check("addr_stable", addr_glitch, 32'd0);

        // start while busy is ignored; start after done repeats the load.
        wr_base = writes;
        rq_base = req_cnt;
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        wait_end("l2", 3000);
        @(negedge clk);
        check("l2_done", {30'd0, done, error}, 32'b10);
        check("l2_single_pass", writes - wr_base, 32'd4);
        check("l2_reqs", req_cnt - rq_base, WORDS + HDR_REQS);
        pulse_start();
        check("restart_clears", {30'd0, done, busy}, 32'b01);
        wait_end("l3", 3000);
        check("l3_writes", writes - wr_base, 32'd8);

        // Reset mid-READ, then a fresh load.
        pulse_start();
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_fvalid", {31'd0, flash_valid}, 32'd0);
        check("midrst_status", {29'd0, busy, done, mem_wr}, 32'd0);
        check("midrst_addr", {8'd0, flash_addr}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        mem[3] = 16'hDEAD;
        wr_base = writes;
        pulse_start();
        wait_end("l4", 3000);
        @(negedge clk);
        check("l4_done", {30'd0, done, busy}, 32'b10);
        check("l4_writes", writes - wr_base, 32'd4);
        check("l4_mem3", {16'd0, mem[3]}, {16'd0, DW0 + 16'd3});
        check("l4_mem0", {16'd0, mem[0]}, {16'd0, DW0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
